mem_fetch_unit: RTL

- Memory-side stage of the multicycle RV32 CPU, between the FSM control unit and a single unified instruction/data bus.
- Holds PC, OldPC, the instruction register (IR) and the read-data register (Data).
- Runs each memory transaction requested by the control unit through a valid/ready bus handshake with variable wait states, timeout and misalignment detection.
- Feeds op/funct3/funct7b5 back to the control unit and signals completion so control states can stall on slow memory.

---
 rtl/mem_fetch_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_fetch_unit.sv
// mem_fetch_unit: memory-side stage of the multicycle RV32 CPU.
// Holds PC, OldPC, the instruction register and the load-data register. It also runs one
// bus transaction per mem_start request over a valid/ready handshake. A transaction ends
// in one of three ways: completion, timeout, or an address/kind fault.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   pc_write, pc_next       PC load request and value
//   mem_start               start one transaction (fetch, load or store)
//   adr_src, ir_write,      address select and transaction kind
//   mem_write
//   alu_addr, write_data    data address and store data
//   bus_*                   unified instruction/data bus (valid/ready)
//   pc, old_pc, instr       architectural fetch state
//   op, funct3, funct7b5    decode fields fed back to the control unit
//   data_reg                last load data
//   mem_busy                high while the request is on the bus
//   mem_done                one-cycle completion pulse
//   mem_fault               sticky fault flag
module mem_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  input  logic            mem_start,
  input  logic            adr_src,
  input  logic            ir_write,
  input  logic            mem_write,
  input  logic [XLEN-1:0] alu_addr,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic            bus_we,
  output logic            bus_valid,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [XLEN-1:0] data_reg,
  output logic            mem_busy,
  output logic            mem_done,
  output logic            mem_fault
);

  localparam logic [31:0] Nop        = 32'h0000_0013;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone,
    StFault
  } state_e;

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_old_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_we;
  logic            r_valid;
  logic            r_fetch;
  logic            r_store;
  logic [7:0]      r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_fault;

  logic [XLEN-1:0] w_addr;
  logic            w_bad;
  logic [7:0]      w_cnt_inc;

  // Uses the PC value from before this edge, so a pc_write in the start cycle has no effect
  // on the fetch address.
  assign w_addr    = adr_src ? alu_addr : r_pc;
  assign w_bad     = (w_addr[1:0] != 2'b00) | (ir_write & mem_write);
  assign w_cnt_inc = r_cnt + 8'd1;

  // The PC can be loaded during a transaction, but not once the unit has faulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (pc_write && (r_state != StFault)) begin
      r_pc <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_old_pc <= '0;
      r_instr  <= Nop;
      r_data   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_valid  <= 1'b0;
      r_fetch  <= 1'b0;
      r_store  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (mem_start) begin
            r_addr  <= w_addr;
            r_wdata <= write_data;
            r_fetch <= ir_write;
            r_store <= mem_write;
            r_cnt   <= '0;
            if (w_bad) begin
              // Bad requests never reach the bus.
              r_fault <= 1'b1;
              r_state <= StFault;
            end else begin
              r_valid <= 1'b1;
              r_we    <= mem_write;
              r_busy  <= 1'b1;
              r_state <= StReq;
            end
          end
        end
        StReq: begin
          // When ready arrives on the timeout edge, ready takes priority.
          if (bus_ready) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
            if (r_fetch) begin
              r_instr  <= bus_rdata[31:0];
              r_old_pc <= r_addr;
            end else if (!r_store) begin
              r_data <= bus_rdata;
            end
          end else if (w_cnt_inc == TimeoutCnt) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
            r_state <= StFault;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        StFault: begin
          r_valid <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_fault <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_we    = r_we;
  assign bus_valid = r_valid;
  assign pc        = r_pc;
  assign old_pc    = r_old_pc;
  assign instr     = r_instr;
  assign op        = r_instr[6:0];
  assign funct3    = r_instr[14:12];
  assign funct7b5  = r_instr[30];
  assign data_reg  = r_data;
  assign mem_busy  = r_busy;
  assign mem_done  = r_done;
  assign mem_fault = r_fault;

endmodule
